bar_height_loader: RTL
======================

Name: bar_height_loader

Overview:
Sequences readout of the bar-height RAM written by the Nios II subsystem into a shadow register bank. On each rising edge of data_back it reads NUM_BARS consecutive RAM words, compensating for the fixed RAM read latency. It then commits the whole set to the VGA controller's height array atomically, during vertical blanking only, so a displayed frame never mixes old and new bars. It replaces the free-running counter/case readout logic in the top level and adds overrun tracking.

Parameters:
NUM_BARS, 20, number of bars read per update (RAM addresses 0..NUM_BARS-1)
HEIGHT_W, 6, width of one bar height / RAM data word
ADDR_W, 6, RAM read-address width; NUM_BARS <= 2**ADDR_W
RAM_LATENCY, 2, cycles from ram_rdaddress driven to matching ram_q valid (1..4)

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge
reset_n  in  1  synchronous, active-low reset
data_back  in  1  Nios "RAM written" flag; update request on 0->1 transition
vblank  in  1  high while VGA is in vertical blanking, already synchronous to CLOCK_50
ram_q  in  HEIGHT_W  bar-height RAM read data
ram_rdaddress  out  ADDR_W  bar-height RAM read address (registered)
height_out  out  NUM_BARS*HEIGHT_W  committed heights, bar k at bits [k*HEIGHT_W +: HEIGHT_W]
busy  out  1  high in any state other than IDLE
commit  out  1  one-cycle pulse on the cycle height_out changes
overrun_cnt  out  8  saturating count of requests that arrived while one was already pending

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; ram_rdaddress=0, height_out=0, shadow=0, busy=0, commit=0, overrun_cnt=0, pending=0, data_back history=0. Takes effect mid-operation; any partial read and the pending request are discarded.
- Edge detect: req = data_back & ~data_back_q, where data_back_q is data_back registered. data_back held high produces exactly one req.
- States: IDLE, READ, DRAIN, WAIT_VBLANK.
- IDLE: on req (cycle t), go to READ and set ram_rdaddress<=0. Addresses 0..NUM_BARS-1 then appear on ram_rdaddress in cycles t+1..t+NUM_BARS, one per cycle, with no gaps.
- READ: increment ram_rdaddress each cycle. Each issued address enters a RAM_LATENCY-deep valid/index pipeline. After issuing NUM_BARS-1, go to DRAIN.
- DRAIN: issues no new addresses; ram_rdaddress returns to 0. When the pipeline delivers index NUM_BARS-1, go to WAIT_VBLANK.
- Capture: shadow[k] <= ram_q in the cycle the pipeline output carries index k. This is RAM_LATENCY cycles after address k was driven.
- The last shadow entry is written at cycle t+NUM_BARS+RAM_LATENCY. The state is WAIT_VBLANK from the following cycle.
- WAIT_VBLANK: in the first cycle with vblank=1, height_out <= shadow (all bars in the same edge) and commit=1 for exactly that cycle. Then go to IDLE, or straight to READ if pending is set.
- If vblank is already high on entry, the commit occurs in the first WAIT_VBLANK cycle.
- Request while busy: first req sets pending=1. A req while pending=1 increments overrun_cnt (saturating at 255, no wrap) and is otherwise dropped.
- A req in the same cycle as the commit counts as arriving while busy.
- A pending request restarts at address 0 on the cycle after commit, and pending clears on that restart.
- height_out changes only on commit cycles. busy = (state != IDLE).
- Widths: ram_rdaddress counter is ADDR_W bits and never exceeds NUM_BARS-1. The bar index pipeline is ceil(log2(NUM_BARS)) bits.

Test Plan:
1. RAM model latency 2, words addr k = k+1. Pulse data_back at cycle 10, vblank high -> rdaddress 0..19 in cycles 11..30. Commit pulse at cycle 33. height_out bar k = k+1. busy high 11..33.
2. Same as test 1 but vblank low until cycle 100 -> height_out unchanged (0) through cycle 99. commit=1 only at the first vblank=1 cycle (100). busy low from cycle 101.
3. Three extra data_back edges during a load -> one restart immediately after commit, overrun_cnt=2. The second load's data (RAM rewritten to 63-k) committed on the next vblank.
4. Assert reset_n=0 for one cycle midway through READ (rdaddress=7) -> next cycle: IDLE, rdaddress=0, height_out=0, pending=0. A subsequent edge performs a clean full load.
5. data_back held high for 200 cycles -> exactly one load and one commit, overrun_cnt=0.
6. 300 edges while stuck in WAIT_VBLANK (vblank low) -> overrun_cnt saturates at 255, no wrap.

Source files
------------

// File: rtl/bar_height_loader.sv
// Copies NUM_BARS words from the bar-height RAM into a shadow bank on each data_back rising edge,
// then commits the full set to height_out in one edge during vertical blanking.
module bar_height_loader #(
  parameter int NUM_BARS    = 20,
  parameter int HEIGHT_W    = 6,
  parameter int ADDR_W      = 6,
  parameter int RAM_LATENCY = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         data_back,
  input  logic                         vblank,
  input  logic [HEIGHT_W-1:0]          ram_q,
  output logic [ADDR_W-1:0]            ram_rdaddress,
  output logic [NUM_BARS*HEIGHT_W-1:0] height_out,
  output logic                         busy,
  output logic                         commit,
  output logic [7:0]                   overrun_cnt
);

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BARS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BARS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_VBLANK} state_e;

  state_e                             state_q, state_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d;
  logic                               pend_q, pend_d;
  logic [7:0]                         ovr_q, ovr_d;
  logic                               db_q;
  logic [NUM_BARS-1:0][HEIGHT_W-1:0]  shadow_q, height_q;
  logic [RAM_LATENCY:1]               vld_pipe;
  logic [RAM_LATENCY:1][IDX_W-1:0]    idx_pipe;
  logic                               req, pend_any, out_vld;
  logic [IDX_W-1:0]                   out_idx;

  assign req           = data_back & ~db_q;
  assign busy          = (state_q != IDLE);
  assign out_vld       = vld_pipe[RAM_LATENCY];
  assign out_idx       = idx_pipe[RAM_LATENCY];
  // A request landing while busy (including the commit cycle) becomes pending.
  assign pend_any      = pend_q | (req & busy);
  assign ram_rdaddress = addr_q;
  assign height_out    = height_q;
  assign overrun_cnt   = ovr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_any;
    ovr_d   = ovr_q;
    commit  = 1'b0;
    if (req && busy && pend_q && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    case (state_q)
      IDLE: if (req) begin
        state_d = READ;
        addr_d  = '0;
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: if (out_vld && out_idx == LAST_IDX) state_d = WAIT_VBLANK;
      WAIT_VBLANK: if (vblank) begin
        commit = 1'b1;
        addr_d = '0;
        if (pend_any) begin
          state_d = READ;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      db_q    <= data_back;
    end
  end

  // Index pipeline mirrors the RAM latency so each ram_q word lands in its own bar slot.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= (state_q == READ);
      idx_pipe[1] <= addr_q[IDX_W-1:0];
      for (int i = 2; i <= RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      shadow_q <= '0;
      height_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BARS; k++)
        if (out_vld && out_idx == IDX_W'(k)) shadow_q[k] <= ram_q;
      if (commit) height_q <= shadow_q;
    end
  end

endmodule
